// File: rtl/parallel_to_serial_buf_pkg.sv
// Shared types and helpers for the parallel-to-serial buffer.
package p2s_pkg;

  typedef enum logic {
    P2S_IDLE  = 1'b0,
    P2S_SHIFT = 1'b1
  } p2s_state_e;

  function automatic int cnt_w(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/parallel_to_serial_buf_hold_buf.sv
// One-entry skid buffer in front of the shifter; owns in_ready.
module p2s_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p_data,
  input  logic             load_req,
  output logic             load_valid,
  output logic [WIDTH-1:0] load_data,
  output logic             hold_full
);

  logic [WIDTH-1:0] hold_reg_q, hold_reg_d;
  logic             hold_full_q, hold_full_d;
  logic             accept;

  assign in_ready  = !hold_full_q;
  assign hold_full = hold_full_q;
  assign accept    = in_valid & in_ready;

  // A held word always wins the reload slot; a fresh word only bypasses the hold when it is empty.
  always_comb begin
    hold_reg_d  = hold_reg_q;
    hold_full_d = hold_full_q;
    load_valid  = 1'b0;
    load_data   = p_data;
    if (load_req && hold_full_q) begin
      load_valid  = 1'b1;
      load_data   = hold_reg_q;
      hold_full_d = 1'b0;
    end else if (load_req && accept) begin
      load_valid = 1'b1;
    end else if (accept) begin
      hold_reg_d  = p_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_reg_q  <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_reg_q  <= hold_reg_d;
      hold_full_q <= hold_full_d;
    end
  end

endmodule

// File: rtl/parallel_to_serial_buf.sv
// Word-to-bit-stream serialiser with valid/ready on both sides and frame markers.
// Handshake: a transfer happens on a rising edge where valid & ready are both high; valid never waits on ready.
module parallel_to_serial_buf
  import p2s_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p_data,
  output logic             s_data,
  output logic             s_valid,
  input  logic             s_ready,
  output logic             frame_start,
  output logic             frame_end,
  output logic             empty,
  output p2s_state_e       dbg_state
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  p2s_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             transfer, last_bit, load_req, load_valid, hold_full;
  logic [WIDTH-1:0] load_data;

  assign s_valid     = (state_q == P2S_SHIFT);
  assign transfer    = s_valid & s_ready;
  assign last_bit    = (bit_cnt_q == LAST_CNT);
  assign load_req    = (state_q == P2S_IDLE) | (transfer & last_bit);
  assign s_data      = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
  assign frame_start = (bit_cnt_q == '0) & s_valid;
  assign frame_end   = last_bit & s_valid;
  assign empty       = (state_q == P2S_IDLE) & !hold_full;
  assign dbg_state   = state_q;

  p2s_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .p_data     (p_data),
    .load_req   (load_req),
    .load_valid (load_valid),
    .load_data  (load_data),
    .hold_full  (hold_full)
  );

  // Clearing the shifter on the way to IDLE keeps s_data at 0 while idle.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (load_valid) begin
      state_d   = P2S_SHIFT;
      shift_d   = load_data;
      bit_cnt_d = '0;
    end else if (transfer) begin
      if (last_bit) begin
        state_d   = P2S_IDLE;
        shift_d   = '0;
        bit_cnt_d = '0;
      end else begin
        shift_d   = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= P2S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_parallel_to_serial_buf.sv
// Bench for parallel_to_serial_buf: a 4-bit MSB-first and an 8-bit LSB-first instance.
module tb_parallel_to_serial_buf;
  import p2s_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       in_valid4 = 1'b0, in_ready4, s_data4, s_valid4, s_ready4 = 1'b1;
  logic       frame_start4, frame_end4, empty4;
  logic [3:0] p_data4 = '0;
  p2s_state_e dbg_state4;

  logic       in_valid8 = 1'b0, in_ready8, s_data8, s_valid8, s_ready8 = 1'b1;
  logic       frame_start8, frame_end8, empty8;
  logic [7:0] p_data8 = '0;
  p2s_state_e dbg_state8;

  logic       sel = 1'b0;  // 0 = 4-bit instance, 1 = 8-bit instance
  logic [0:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  wire m_valid = sel ? s_valid8     : s_valid4;
  wire m_data  = sel ? s_data8      : s_data4;
  wire m_fs    = sel ? frame_start8 : frame_start4;
  wire m_fe    = sel ? frame_end8   : frame_end4;
  wire m_rdy   = sel ? in_ready8    : in_ready4;
  wire m_empty = sel ? empty8       : empty4;

  parallel_to_serial_buf #(.WIDTH(4), .MSB_FIRST(1'b1)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .p_data(p_data4),
    .s_data(s_data4), .s_valid(s_valid4), .s_ready(s_ready4), .frame_start(frame_start4),
    .frame_end(frame_end4), .empty(empty4), .dbg_state(dbg_state4)
  );

  parallel_to_serial_buf #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .p_data(p_data8),
    .s_data(s_data8), .s_valid(s_valid8), .s_ready(s_ready8), .frame_start(frame_start8),
    .frame_end(frame_end8), .empty(empty8), .dbg_state(dbg_state8)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Drive one word on the selected instance; push its bits in transmit order once it is accepted.
  task automatic drive_word(input logic [7:0] w);
    bit done = 0;
    if (sel) begin in_valid8 = 1'b1; p_data8 = w; end
    else     begin in_valid4 = 1'b1; p_data4 = w[3:0]; end
    for (int k = 0; k < 20 && !done; k++) begin
      if (m_rdy) begin
        if (sel) for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
        else     for (int i = 3; i >= 0; i--) exp_q.push_back(w[i]);
        done = 1;
      end
      @(negedge clk);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout got in_ready=%0b exp 1", m_rdy);
    end
    in_valid4 = 1'b0;
    in_valid8 = 1'b0;
  endtask

  // Consume nbits from the selected instance with a per-cycle s_ready pattern; returns cycles from first valid bit.
  task automatic drain(input int nbits, input logic [15:0] pat, input int budget, output int cycles);
    int    got = 0, pos = 0, k = 0, w;
    bit    started = 0, prev_stall = 0;
    logic  prev_bit = 1'b0, r, e;
    w = sel ? 8 : 4;
    cycles = 0;
    while (got < nbits && k < budget) begin
      r = (k < 16) ? pat[k] : 1'b1;
      s_ready4 = r;
      s_ready8 = r;
      if (m_valid) started = 1;
      if (started) begin
        cycles++;
        checks++;
        if (m_valid !== 1'b1) begin
          errors++;
          $display("FAIL gap got s_valid=%0b exp 1", m_valid);
        end
        if (prev_stall) begin
          checks++;
          if (m_data !== prev_bit) begin
            errors++;
            $display("FAIL stall_hold got %0b exp %0b", m_data, prev_bit);
          end
        end
      end
      if (m_valid && r) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_bit got %0b exp none", m_data);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (m_data !== e || m_fs !== (pos == 0) || m_fe !== (pos == w - 1)) begin
            errors++;
            $display("FAIL bit%0d got d=%0b fs=%0b fe=%0b exp d=%0b fs=%0b fe=%0b",
                     got, m_data, m_fs, m_fe, e, pos == 0, pos == w - 1);
          end
        end
        pos = (pos + 1) % w;
        got++;
        prev_stall = 0;
      end else if (m_valid) begin
        prev_stall = 1;
        prev_bit = m_data;
      end
      k++;
      @(negedge clk);
    end
    checks++;
    if (got != nbits) begin
      errors++;
      $display("FAIL drain_timeout got %0d bits exp %0d", got, nbits);
    end
    s_ready4 = 1'b1;
    s_ready8 = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if ({empty4, in_ready4, s_valid4, s_data4, frame_start4, frame_end4} !== 6'b110000) begin
      errors++;
      $display("FAIL reset4 got e/ir/v/d/fs/fe=%b exp 110000",
               {empty4, in_ready4, s_valid4, s_data4, frame_start4, frame_end4});
    end
    checks++;
    if ({empty8, in_ready8, s_valid8, s_data8} !== 4'b1100) begin
      errors++;
      $display("FAIL reset8 got e/ir/v/d=%b exp 1100", {empty8, in_ready8, s_valid8, s_data8});
    end
  endtask

  task automatic test_single();
    int cyc;
    sel = 1'b0;
    drive_word(8'h0A);
    drain(4, 16'hFFFF, 20, cyc);
    checks++;
    if (cyc != 4) begin errors++; $display("FAIL single_cycles got %0d exp 4", cyc); end
    checks++;
    if (m_valid !== 1'b0 || m_empty !== 1'b1) begin
      errors++;
      $display("FAIL single_idle got v=%0b empty=%0b exp v=0 empty=1", m_valid, m_empty);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    sel = 1'b0;
    fork
      begin
        drive_word(8'h0F);
        drive_word(8'h05);
        checks++;
        if (in_ready4 !== 1'b0) begin
          errors++;
          $display("FAIL b2b_in_ready got %0b exp 0", in_ready4);
        end
      end
      drain(8, 16'hFFFF, 40, cyc);
    join
    checks++;
    if (cyc != 8) begin errors++; $display("FAIL b2b_cycles got %0d exp 8", cyc); end
    checks++;
    if (empty4 !== 1'b1) begin errors++; $display("FAIL b2b_empty got %0b exp 1", empty4); end
  endtask

  task automatic test_lsb_first();
    int cyc;
    sel = 1'b1;
    drive_word(8'hB4);
    drain(8, 16'hFFFF, 30, cyc);
    checks++;
    if (cyc != 8) begin errors++; $display("FAIL lsb_cycles got %0d exp 8", cyc); end
    checks++;
    if (empty8 !== 1'b1 || s_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL lsb_idle got empty=%0b v=%0b exp 1 0", empty8, s_valid8);
    end
    sel = 1'b0;
  endtask

  task automatic test_stall();
    int cyc;
    sel = 1'b0;
    drive_word(8'h0C);
    drain(4, 16'hFFF9, 30, cyc);
    checks++;
    if (cyc != 6) begin errors++; $display("FAIL stall_cycles got %0d exp 6", cyc); end
    checks++;
    if (empty4 !== 1'b1) begin errors++; $display("FAIL stall_empty got %0b exp 1", empty4); end
  endtask

  task automatic test_reset_mid_word();
    sel = 1'b0;
    s_ready4 = 1'b1;
    in_valid4 = 1'b1;
    p_data4 = 4'b1001;
    @(negedge clk);
    p_data4 = 4'b0110;
    checks++;
    if (s_data4 !== 1'b1 || frame_start4 !== 1'b1) begin
      errors++;
      $display("FAIL rmw_bit0 got d=%0b fs=%0b exp 1 1", s_data4, frame_start4);
    end
    @(negedge clk);
    in_valid4 = 1'b0;
    checks++;
    if (s_data4 !== 1'b0 || in_ready4 !== 1'b0) begin
      errors++;
      $display("FAIL rmw_bit1 got d=%0b ir=%0b exp 0 0", s_data4, in_ready4);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({empty4, in_ready4, s_valid4, s_data4, frame_start4, frame_end4} !== 6'b110000) begin
      errors++;
      $display("FAIL rmw_async got e/ir/v/d/fs/fe=%b exp 110000",
               {empty4, in_ready4, s_valid4, s_data4, frame_start4, frame_end4});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (s_valid4 !== 1'b0 || empty4 !== 1'b1) begin
        errors++;
        $display("FAIL rmw_post%0d got v=%0b empty=%0b exp 0 1", i, s_valid4, empty4);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_lsb_first();
    test_stall();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parallel_to_serial_buf.md
Name: parallel_to_serial_buf

Overview:
- Parametrised successor to the 4-bit parallel-to-serial converter.
- Accepts WIDTH-bit words over a valid/ready handshake into a one-word holding buffer, then serialises them MSB- or LSB-first.
- Output is a bit stream with its own valid/ready flow control and frame markers.
- Back-to-back words stream with no idle gap; sits between word-oriented producers and serial link/encoder blocks.

Parameters:
- WIDTH, 8, bits per parallel word; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit p_data[WIDTH-1] first; 0 = transmit p_data[0] first.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
- in_valid  input  1  producer has a word on p_data.
- in_ready  output  1  block can accept a word this cycle.
- p_data  input  WIDTH  parallel word; sampled only on the accept cycle (in_valid & in_ready).
- s_data  output  1  current serial bit; driven from a register.
- s_valid  output  1  s_data holds a valid bit.
- s_ready  input  1  consumer takes the bit this cycle (s_valid & s_ready = bit transfer).
- frame_start  output  1  high while the current bit is bit 0 of a word in transmit order.
- frame_end  output  1  high while the current bit is the last bit of a word.
- empty  output  1  shifter idle and holding buffer empty.

Behaviour:
- Reset values (rst low): in_ready=1, s_data=0, s_valid=0, frame_start=0, frame_end=0, empty=1; bit counter=0; hold_full=0; FSM=IDLE.
- Storage is shift_reg[WIDTH], hold_reg[WIDTH] plus hold_full, and bit_cnt of width $clog2(WIDTH).
- FSM IDLE: s_valid=0, s_data=0.
  - A word accepted at edge N loads shift_reg directly, sets bit_cnt=0 and moves the FSM to SHIFT.
  - From edge N: s_valid=1, s_data=first bit, frame_start=1.
  - One-cycle accept-to-first-bit latency.
- FSM SHIFT: s_valid=1.
  - On transfer with bit_cnt<WIDTH-1: shift toward the output end, bit_cnt+1.
  - On transfer with bit_cnt=WIDTH-1 (last bit):
    - hold_full=1: load shift_reg from hold_reg, clear hold_full, bit_cnt=0, stay SHIFT. No gap.
    - else an input accepted in the same cycle: load that word directly, stay SHIFT.
    - else return to IDLE.
  - Without a transfer (s_ready=0), shift_reg, bit_cnt and s_data hold stable. No bit is ever dropped or repeated.
- in_ready = !hold_full (registered-state only; no combinational path from s_ready to in_ready).
  - An accept while in SHIFT that is not taken by a last-bit reload goes into hold_reg and sets hold_full.
- Simultaneous events:
  - Accept with hold empty on the last-bit transfer cycle goes straight to the shifter; hold stays empty.
  - Accept while hold_full=1 is impossible, because in_ready=0.
- frame_start = (bit_cnt==0) & s_valid.
- frame_end = (bit_cnt==WIDTH-1) & s_valid.
- empty = (FSM==IDLE) & !hold_full.
- Ordering:
  - MSB_FIRST=1: s_data = shift_reg[WIDTH-1], shift left.
  - MSB_FIRST=0: s_data = shift_reg[0], shift right.
  - Zero fill in both modes.
- Reset mid-word: the partial word and any held word are discarded; outputs return to reset values asynchronously. No bits are emitted after rst is released until a new accept.
- Throughput: 1 bit/cycle sustained when s_ready=1 and the producer keeps the hold buffer full.

Decomposition:
- Shared package p2s_pkg:
  - state enum (P2S_IDLE, P2S_SHIFT).
  - function cnt_w(WIDTH) returning $clog2(WIDTH).
- Natural sub-module: p2s_hold_buf. It owns the one-entry skid buffer: hold_reg, hold_full, in_ready, and the handshake into the shifter.
- The top contains the FSM, shifter and counter.

Test Plan:
- Reset release, WIDTH=4, MSB_FIRST=1, s_ready=1 -> empty=1, in_ready=1, s_valid=0, s_data=0.
- Single word 4'b1010 accepted -> s_data = 1,0,1,0 on 4 consecutive cycles. frame_start on cycle 1, frame_end on cycle 4. Then s_valid=0 and empty=1.
- Back-to-back 4'b1111 then 4'b0101 with in_valid held high -> 8 contiguous bits 1,1,1,1,0,1,0,1 with no gap. in_ready drops while hold is full.
- MSB_FIRST=0, WIDTH=8, word 8'hB4 -> bits 0,0,1,0,1,1,0,1.
- s_ready toggled 1,0,0,1 during word 4'b1100 -> s_data holds during stalls; exactly 4 transfers of 1,1,0,0.
- rst asserted after the 2nd bit of 4'b1001, with another word held -> all outputs return to reset values immediately. After release: s_valid=0 and empty=1 until a new accept.
